// File: rtl/seg_rx_pkg.sv
// Shared constants for the serial 7-segment receiver: frame layout, FSM states,
// segment bit positions and the hex glyph table.
package seg_rx_pkg;

  localparam int unsigned FRAME_LEN = 12;
  localparam int unsigned IDX_BITS  = 4;
  localparam int unsigned SEG_BITS  = FRAME_LEN - IDX_BITS;

  // Receiver FSM states, encoding fixed for compatibility with older benches.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  // Segment byte layout {dp,g,f,e,d,c,b,a}.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Glyph for hex value v is GLYPH[v], pattern bits [g:a].
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to hex decoder. The decimal point is ignored; any
// pattern that is not one of the 16 glyphs (including blank) gives ok=0, val=0.
module seg7_decode
  import seg_rx_pkg::*;
(
  input  logic [7:0] i_pattern,
  output logic       o_ok,
  output logic [3:0] o_val
);

  logic [6:0] w_glyph;

  assign w_glyph = i_pattern[SEG_G:SEG_A];

  // Table lookup; glyphs are unique so at most one entry matches.
  always_comb begin
    o_ok  = 1'b0;
    o_val = 4'd0;
    for (int v = 0; v < 16; v++) begin
      if (w_glyph == GLYPH[v]) begin
        o_ok  = 1'b1;
        o_val = 4'(v);
      end
    end
  end

endmodule

// File: rtl/seg_serial_rx.sv
// Receiving end of the serial 7-segment link. Deserializes 12-bit frames
// (4-bit digit index then segment byte, MSB first) into per-digit registers
// and decodes each stored pattern back to a hex value.
module seg_serial_rx
  import seg_rx_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    CLK,
  input  logic                    RST_X,
  input  logic                    SEG_IN,
  input  logic                    SEG_SEL_IN,
  output logic [8*NUM_DIGITS-1:0] DIGIT_SEG,
  output logic [4*NUM_DIGITS-1:0] DIGIT_VAL,
  output logic [NUM_DIGITS-1:0]   DIGIT_OK,
  output logic                    FRAME_DONE,
  output logic                    FRAME_ERR
);

  state_e                  r_state;
  state_e                  w_state_d;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_d;
  logic [FRAME_LEN-2:0]    r_shift;
  logic [FRAME_LEN-2:0]    w_shift_d;
  logic [8*NUM_DIGITS-1:0] r_seg;
  logic                    r_done;
  logic                    r_err;
  logic                    w_done_d;
  logic                    w_err_d;
  logic                    w_commit;

  logic [FRAME_LEN-1:0]    w_frame;
  logic [IDX_BITS-1:0]     w_idx;
  logic [SEG_BITS-1:0]     w_pat;
  logic                    w_idx_ok;
  logic                    w_last;

  // The full frame only exists combinationally on the edge that samples bit 11.
  assign w_frame  = {r_shift, SEG_IN};
  assign w_idx    = w_frame[FRAME_LEN-1 -: IDX_BITS];
  assign w_pat    = w_frame[SEG_BITS-1:0];
  assign w_idx_ok = 32'(w_idx) < NUM_DIGITS;
  assign w_last   = r_cnt == 4'(FRAME_LEN - 1);

  // Next-state logic for the frame FSM, bit counter and shift register.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_shift_d = r_shift;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (SEG_SEL_IN) begin
          w_shift_d = w_frame[FRAME_LEN-2:0];
          w_cnt_d   = 4'd1;
          w_state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (SEG_SEL_IN) begin
          w_shift_d = w_frame[FRAME_LEN-2:0];
          if (w_last) begin
            w_cnt_d   = 4'd0;
            w_state_d = WAIT_LOW;
            w_commit  = w_idx_ok;
            w_done_d  = w_idx_ok;
            w_err_d   = !w_idx_ok;
          end else begin
            w_cnt_d = r_cnt + 4'd1;
          end
        end else begin
          // Short frame: drop the partial data.
          w_err_d   = 1'b1;
          w_cnt_d   = 4'd0;
          w_shift_d = '0;
          w_state_d = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!SEG_SEL_IN) begin
          w_state_d = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM, counter, shift register and status pulse registers.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_shift <= w_shift_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

  // Per-digit segment registers; only the addressed digit is written on commit.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_seg <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (w_commit && (w_idx == 4'(k))) begin
          r_seg[8*k +: 8] <= w_pat;
        end
      end
    end
  end

  // Decode straight from the stored pattern so value and ok track the segment
  // register, including its reset value (blank -> ok=0, val=0).
  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_dec
    seg7_decode u_dec (
      .i_pattern (r_seg[8*g +: 8]),
      .o_ok      (DIGIT_OK[g]),
      .o_val     (DIGIT_VAL[4*g +: 4])
    );
  end

  assign DIGIT_SEG  = r_seg;
  assign FRAME_DONE = r_done;
  assign FRAME_ERR  = r_err;

endmodule
